xyz_stepper: RTL

Synthesizable source stage for the x/y/z lab monitor. It holds a free-running WIDTH-bit counter `x` that steps once every PERIOD clocks and can be loaded at any time. Each new value of `x` becomes a sample triple {x, y=x+1, z=x+2}, built in a 2-stage pipeline. Triples are buffered in a DEPTH-entry FIFO and drained by the downstream monitor/logger over a valid/ready handshake.

---
 rtl/xyz_stepper.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/xyz_stepper.sv
// xyz_stepper: source stage for the x/y/z lab monitor.
//
// A WIDTH-bit counter x steps once every PERIOD clocks, and load_val can be
// loaded into it at any time. Every change of x, whether an increment or a
// load, produces the triple {x, x+1, x+2}. The triple is built in a 2-stage
// pipeline and buffered in a DEPTH-entry FIFO. The downstream monitor drains
// that FIFO.
//
// Ports
//   clk         sole clock, rising edge
//   reset       synchronous, active-high; clears all state
//   load        load load_val into x this cycle (wins over an increment)
//   load_val    value loaded into x
//   x           current counter value
//   out_valid   FIFO head holds a triple
//   out_ready   consumer accepts the head this cycle
//   out_x/y/z   head triple; holds the last popped triple when empty
//   fifo_count  number of stored triples (0..DEPTH)
//   overflow    sticky; a triple arrived while full and was dropped
//
// Handshake: a triple moves on every rising edge where out_valid && out_ready.
// out_ready is ignored while out_valid is low. out_valid never depends
// combinationally on out_ready. Once out_valid is high, the head stays stable
// until it is popped.
module xyz_stepper #(
  parameter int WIDTH  = 32,
  parameter int PERIOD = 7,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [WIDTH-1:0]         load_val,
  output logic [WIDTH-1:0]         x,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_x,
  output logic [WIDTH-1:0]         out_y,
  output logic [WIDTH-1:0]         out_z,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int TW = $clog2(PERIOD);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [TW-1:0]    TICK_LAST = TW'(PERIOD - 1);
  localparam logic [TW-1:0]    TICK_ONE  = TW'(1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [PW-1:0]    PTR_ONE   = PW'(1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]    CNT_FULL  = CW'(DEPTH);

  // ---------------------------------------------------------------------
  // Counter and tick timer
  // ---------------------------------------------------------------------
  logic [TW-1:0]    tick_q, tick_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             tick_wrap;
  logic             evt;

  always_comb begin
    tick_wrap = (tick_q == TICK_LAST);
    evt       = load | tick_wrap;
    x_d       = x_q;
    tick_d    = tick_q + TICK_ONE;
    // A load restarts the period, so the next increment comes PERIOD clocks
    // after the load.
    if (load) begin
      x_d    = load_val;
      tick_d = '0;
    end else if (tick_wrap) begin
      x_d    = x_q + ONE;
      tick_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q    <= '0;
      tick_q <= '0;
    end else begin
      x_q    <= x_d;
      tick_q <= tick_d;
    end
  end

  // ---------------------------------------------------------------------
  // Two-stage triple builder. It never stalls; one slot per event.
  // ---------------------------------------------------------------------
  logic             s1_v_q;
  logic [WIDTH-1:0] s1_x_q, s1_y_q;
  logic             s2_v_q;
  logic [WIDTH-1:0] s2_x_q, s2_y_q, s2_z_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= evt;
      s2_v_q <= s1_v_q;
    end
  end

  always_ff @(posedge clk) begin
    s1_x_q <= x_d;
    s1_y_q <= x_d + ONE;
    s2_x_q <= s1_x_q;
    s2_y_q <= s1_y_q;
    s2_z_q <= s1_y_q + ONE;
  end

  // ---------------------------------------------------------------------
  // Output FIFO with registered head
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] mem_x [DEPTH];
  logic [WIDTH-1:0] mem_y [DEPTH];
  logic [WIDTH-1:0] mem_z [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    remain;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] ox_q, ox_d, oy_q, oy_d, oz_q, oz_d;
  logic             pop, push, drop;

  always_comb begin
    pop  = (cnt_q != '0) & out_ready;
    // When the FIFO is full, a same-cycle pop frees the slot for the arriving triple.
    push = s2_v_q & ((cnt_q != CNT_FULL) | pop);
    drop = s2_v_q & ~push;

    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;

    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_ONE;
    end

    ovf_d = ovf_q | drop;

    // Head after this edge. Choose the oldest surviving stored entry.
    // If none survives, choose the arriving triple.
    // If nothing arrives either, keep the last popped value.
    remain = pop ? cnt_q - CNT_ONE : cnt_q;
    ox_d   = ox_q;
    oy_d   = oy_q;
    oz_d   = oz_q;
    if (remain != '0) begin
      ox_d = mem_x[rd_ptr_d];
      oy_d = mem_y[rd_ptr_d];
      oz_d = mem_z[rd_ptr_d];
    end else if (push) begin
      ox_d = s2_x_q;
      oy_d = s2_y_q;
      oz_d = s2_z_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_ptr_q] <= s2_x_q;
      mem_y[wr_ptr_q] <= s2_y_q;
      mem_z[wr_ptr_q] <= s2_z_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      ox_q     <= '0;
      oy_q     <= '0;
      oz_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      oz_q     <= oz_d;
    end
  end

  assign x          = x_q;
  assign out_valid  = (cnt_q != '0);
  assign out_x      = ox_q;
  assign out_y      = oy_q;
  assign out_z      = oz_q;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;

endmodule
